// File: rtl/calc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : calc_ctrl_pkg
//  Description : Shared calculator definitions: key class encodings, the
//                key-entry controller state encoding and a key decode helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package calc_ctrl_pkg;

    // Key class encodings carried on key_type
    localparam logic [1:0] KEY_OPND = 2'b00;
    localparam logic [1:0] KEY_ADD  = 2'b01;
    localparam logic [1:0] KEY_SUB  = 2'b10;
    localparam logic [1:0] KEY_EQ   = 2'b11;

    // Key-entry controller states (explicit 3-bit encoding)
    typedef enum logic [2:0] {
        S_A   = 3'd0,   // waiting for operand A
        S_OP  = 3'd1,   // A held, waiting for operator
        S_B   = 3'd2,   // A and operator held, waiting for operand B
        S_EQ  = 3'd3,   // A, operator and B held
        S_RES = 3'd4    // result held in A
    } state_t;

    // True for the two arithmetic operator keys
    function automatic logic is_operator(input logic [1:0] kt);
        return (kt == KEY_ADD) || (kt == KEY_SUB);
    endfunction

endpackage : calc_ctrl_pkg
`default_nettype wire

// File: rtl/add_sub.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder / add_sub
//  Description : One-bit full adder and an n-bit ripple adder/subtractor
//                built from it. ctr=0 adds, ctr=1 subtracts (a + ~b + 1).
//  Ports (add_sub):
//    a, b   in  n  operands
//    ctr    in  1  0 add, 1 subtract
//    s      out n  sum / difference modulo 2^n
//    cout   out 1  carry out (for subtract: 1 = no borrow)
//  Revision    : 1.0 - initial release
// ============================================================================
module full_adder (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = x ^ y ^ cin;
    assign cout = (x & y) | (cin & (x ^ y));
endmodule : full_adder

module add_sub #(
    parameter int n = 4
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         ctr,
    output logic [n-1:0] s,
    output logic         cout
);
    // Subtraction is addition of the inverted operand with carry-in set
    logic [n-1:0] w_bx;
    logic [n:0]   w_c;

    assign w_bx   = b ^ {n{ctr}};
    assign w_c[0] = ctr;

    generate
        for (genvar gi = 0; gi < n; gi++) begin : g_bit
            full_adder u_fa (
                .x    (a[gi]),
                .y    (w_bx[gi]),
                .cin  (w_c[gi]),
                .s    (s[gi]),
                .cout (w_c[gi+1])
            );
        end
    endgenerate

    assign cout = w_c[n];
endmodule : add_sub
`default_nettype wire

// File: rtl/calc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : calc_ctrl
//  Description : Sequential key-entry controller for the calculator. Collects
//                operand / operator / equals keys, holds A, B and the pending
//                operation, drives add_sub and registers result and flags.
//  Ports:
//    clk           in   1  rising-edge clock
//    rst_n         in   1  asynchronous active-low reset
//    key_valid     in   1  key strobe, one key per cycle when high
//    key_type      in   2  00 operand, 01 add, 10 subtract, 11 equals
//    key_data      in   N  operand value (key_type=00 only)
//    disp          out  N  last entered operand or last result
//    result_valid  out  1  one-cycle pulse: new result on disp
//    cout          out  1  carry of last computation (sub: 1 = no borrow)
//    ovf           out  1  signed overflow of last computation
//    err           out  1  one-cycle pulse: key illegal here, ignored
//  Revision    : 1.0 - initial release
// ============================================================================
module calc_ctrl
    import calc_ctrl_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    input  logic [1:0]   key_type,
    input  logic [N-1:0] key_data,
    output logic [N-1:0] disp,
    output logic         result_valid,
    output logic         cout,
    output logic         ovf,
    output logic         err
);

    state_t       r_state;
    logic [N-1:0] r_a;
    logic [N-1:0] r_b;
    logic         r_sub;
    logic [N-1:0] r_disp;
    logic         r_result_valid;
    logic         r_cout;
    logic         r_ovf;
    logic         r_err;

    logic [N-1:0] w_s;
    logic         w_cout;
    logic [N-1:0] w_bx;
    logic         w_ovf;
    logic         w_opnd;
    logic         w_eq;
    logic         w_oper;
    logic         w_new_sub;

    // The adder always sees the held operands; its outputs only matter on a
    // compute event, when they are captured below.
    add_sub #(
        .n (N)
    ) u_add_sub (
        .a    (r_a),
        .b    (r_b),
        .ctr  (r_sub),
        .s    (w_s),
        .cout (w_cout)
    );

    // Overflow: effective operands share a sign that the result does not
    assign w_bx  = r_b ^ {N{r_sub}};
    assign w_ovf = (r_a[N-1] == w_bx[N-1]) && (w_s[N-1] != r_a[N-1]);

    assign w_opnd    = (key_type == KEY_OPND);
    assign w_eq      = (key_type == KEY_EQ);
    assign w_oper    = is_operator(key_type);
    assign w_new_sub = (key_type == KEY_SUB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_A;
            r_a            <= '0;
            r_b            <= '0;
            r_sub          <= 1'b0;
            r_disp         <= '0;
            r_result_valid <= 1'b0;
            r_cout         <= 1'b0;
            r_ovf          <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            // Pulses are cleared every cycle and re-armed only by a key
            r_result_valid <= 1'b0;
            r_err          <= 1'b0;

            if (key_valid) begin
                case (r_state)
                    S_A: begin
                        if (w_opnd) begin
                            r_a     <= key_data;
                            r_disp  <= key_data;
                            r_state <= S_OP;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end

                    S_OP: begin
                        if (w_opnd) begin
                            r_a    <= key_data;
                            r_disp <= key_data;
                        end else if (w_oper) begin
                            r_sub   <= w_new_sub;
                            r_state <= S_B;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end

                    S_B: begin
                        if (w_opnd) begin
                            r_b     <= key_data;
                            r_disp  <= key_data;
                            r_state <= S_EQ;
                        end else if (w_oper) begin
                            r_sub <= w_new_sub;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end

                    S_EQ: begin
                        if (w_opnd) begin
                            r_b    <= key_data;
                            r_disp <= key_data;
                        end else begin
                            // Equals or chained operator: compute with the
                            // operation already held in r_sub.
                            r_a            <= w_s;
                            r_disp         <= w_s;
                            r_cout         <= w_cout;
                            r_ovf          <= w_ovf;
                            r_result_valid <= 1'b1;
                            if (w_eq) begin
                                r_state <= S_RES;
                            end else begin
                                r_sub   <= w_new_sub;
                                r_state <= S_B;
                            end
                        end
                    end

                    S_RES: begin
                        if (w_opnd) begin
                            // Fresh start; flags keep the last result's values
                            r_a     <= key_data;
                            r_disp  <= key_data;
                            r_state <= S_OP;
                        end else if (w_oper) begin
                            r_sub   <= w_new_sub;
                            r_state <= S_B;
                        end else begin
                            // Repeat-equals: same B, same operation
                            r_a            <= w_s;
                            r_disp         <= w_s;
                            r_cout         <= w_cout;
                            r_ovf          <= w_ovf;
                            r_result_valid <= 1'b1;
                        end
                    end

                    default: begin
                        r_state <= S_A;
                    end
                endcase
            end
        end
    end

    assign disp         = r_disp;
    assign result_valid = r_result_valid;
    assign cout         = r_cout;
    assign ovf          = r_ovf;
    assign err          = r_err;

endmodule : calc_ctrl
`default_nettype wire

// File: tb/tb_calc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_calc_ctrl
//  Description : Self-checking bench for calc_ctrl (N=4). Directed key
//                sequences with constant expectations, then random key
//                streams with occasional resets against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_calc_ctrl;

    localparam int N = 4;
    localparam int M = 1 << N;

    localparam logic [1:0] T_OPND = 2'b00;
    localparam logic [1:0] T_ADD  = 2'b01;
    localparam logic [1:0] T_SUB  = 2'b10;
    localparam logic [1:0] T_EQ   = 2'b11;

    logic         clk;
    logic         rst_n;
    logic         key_valid;
    logic [1:0]   key_type;
    logic [N-1:0] key_data;
    logic [N-1:0] disp;
    logic         result_valid;
    logic         cout;
    logic         ovf;
    logic         err;

    int n_checks;
    int n_errors;

    // Behavioural model: what has been entered so far, in plain integers
    typedef enum int {P_NEED_A, P_HAVE_A, P_NEED_B, P_HAVE_B, P_RESULT} phase_t;
    phase_t m_phase;
    int     m_a, m_b, m_disp;
    bit     m_sub, m_rv, m_cout, m_ovf, m_err;

    calc_ctrl #(
        .N (N)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_valid    (key_valid),
        .key_type     (key_type),
        .key_data     (key_data),
        .disp         (disp),
        .result_valid (result_valid),
        .cout         (cout),
        .ovf          (ovf),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = P_NEED_A;
        m_a = 0; m_b = 0; m_disp = 0;
        m_sub = 0; m_rv = 0; m_cout = 0; m_ovf = 0; m_err = 0;
    endtask

    function automatic int to_signed(input int v);
        return (v >= M/2) ? v - M : v;
    endfunction

    // Evaluate A op B arithmetically and latch result and flags
    task automatic model_compute();
        int r, sr;
        r  = m_sub ? (m_a - m_b) : (m_a + m_b);
        sr = m_sub ? (to_signed(m_a) - to_signed(m_b)) : (to_signed(m_a) + to_signed(m_b));
        m_cout = m_sub ? (m_a >= m_b) : (r >= M);
        m_ovf  = (sr > M/2 - 1) || (sr < -(M/2));
        m_a    = ((r % M) + M) % M;
        m_disp = m_a;
        m_rv   = 1;
    endtask

    task automatic model_key(input bit v, input logic [1:0] t, input int d);
        bit is_op;
        is_op = (t == T_ADD) || (t == T_SUB);
        m_rv = 0;
        m_err = 0;
        if (v) begin
            case (m_phase)
                P_NEED_A: if (t == T_OPND) begin m_a = d; m_disp = d; m_phase = P_HAVE_A; end
                          else m_err = 1;
                P_HAVE_A: if (t == T_OPND) begin m_a = d; m_disp = d; end
                          else if (is_op) begin m_sub = (t == T_SUB); m_phase = P_NEED_B; end
                          else m_err = 1;
                P_NEED_B: if (t == T_OPND) begin m_b = d; m_disp = d; m_phase = P_HAVE_B; end
                          else if (is_op) m_sub = (t == T_SUB);
                          else m_err = 1;
                P_HAVE_B: if (t == T_OPND) begin m_b = d; m_disp = d; end
                          else if (t == T_EQ) begin model_compute(); m_phase = P_RESULT; end
                          else begin model_compute(); m_sub = (t == T_SUB); m_phase = P_NEED_B; end
                P_RESULT: if (t == T_OPND) begin m_a = d; m_disp = d; m_phase = P_HAVE_A; end
                          else if (is_op) begin m_sub = (t == T_SUB); m_phase = P_NEED_B; end
                          else model_compute();
                default:  m_phase = P_NEED_A;
            endcase
        end
    endtask

    task automatic check_outputs();
        check("disp",         32'(disp),         32'(m_disp));
        check("result_valid", 32'(result_valid), 32'(m_rv));
        check("cout",         32'(cout),         32'(m_cout));
        check("ovf",          32'(ovf),          32'(m_ovf));
        check("err",          32'(err),          32'(m_err));
    endtask

    // Present one key for one cycle, then compare one time unit after the edge
    task automatic key(input bit v, input logic [1:0] t, input int d);
        @(negedge clk);
        key_valid = v;
        key_type  = t;
        key_data  = N'(d);
        @(posedge clk);
        model_key(v, t, d);
        #1;
        check_outputs();
    endtask

    // Asynchronous reset applied away from the clock edge
    task automatic do_reset();
        @(negedge clk);
        key_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_disp", 32'(disp),         32'd0);
        check("rst_rv",   32'(result_valid), 32'd0);
        check("rst_cout", 32'(cout),         32'd0);
        check("rst_ovf",  32'(ovf),          32'd0);
        check("rst_err",  32'(err),          32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic opnd(input int d); key(1, T_OPND, d); endtask
    task automatic add_k();           key(1, T_ADD, 0);  endtask
    task automatic sub_k();           key(1, T_SUB, 0);  endtask
    task automatic eq_k();            key(1, T_EQ, 0);   endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        key_valid = 1'b0;
        key_type  = 2'b00;
        key_data  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("init_disp", 32'(disp), 32'd0);
        check("init_flags", {28'd0, result_valid, cout, ovf, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Illegal equals from the empty state, then operator replacement
        eq_k();
        check("tp_err_pulse", 32'(err), 32'd1);
        check("tp_err_disp",  32'(disp), 32'd0);
        opnd(4); add_k(); sub_k(); opnd(1); eq_k();
        check("tp_replace", 32'(disp), 32'd3);
        check("tp_replace_rv", 32'(result_valid), 32'd1);

        // 3 + 5 = 8 with signed overflow
        opnd(3); add_k(); opnd(5); eq_k();
        check("tp_add_disp", 32'(disp), 32'd8);
        check("tp_add_cout", 32'(cout), 32'd0);
        check("tp_add_ovf",  32'(ovf),  32'd1);
        check("tp_add_rv",   32'(result_valid), 32'd1);
        key(0, T_EQ, 0);
        check("tp_add_rv_off", 32'(result_valid), 32'd0);

        // 7 - 2 = 5, no borrow
        opnd(7); sub_k(); opnd(2); eq_k();
        check("tp_sub_disp", 32'(disp), 32'd5);
        check("tp_sub_cout", 32'(cout), 32'd1);
        check("tp_sub_ovf",  32'(ovf),  32'd0);

        // 2 - 3 = F with borrow
        opnd(2); sub_k(); opnd(3); eq_k();
        check("tp_borrow_disp", 32'(disp), 32'hF);
        check("tp_borrow_cout", 32'(cout), 32'd0);
        check("tp_borrow_ovf",  32'(ovf),  32'd0);

        // Chaining and repeat-equals: 2, 4, 6
        opnd(1); add_k(); opnd(1); add_k();
        check("tp_chain1", {27'd0, result_valid, disp}, {27'd0, 1'b1, 4'd2});
        opnd(2); eq_k();
        check("tp_chain2", {27'd0, result_valid, disp}, {27'd0, 1'b1, 4'd4});
        eq_k();
        check("tp_chain3", {27'd0, result_valid, disp}, {27'd0, 1'b1, 4'd6});

        // Reset mid-entry discards everything
        opnd(5); add_k();
        do_reset();
        eq_k();
        check("tp_post_rst_err", 32'(err), 32'd1);

        // Random key streams with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                key($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), int'($urandom_range(0, M - 1)));
                check("excl_pulses", 32'(result_valid & err), 32'd0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_calc_ctrl
`default_nettype wire
